breach_dispatcher: RTL and testbench

BREACH_DISPATCHER -- requirements
Module: breach_dispatcher

---
 rtl/dispatch_pkg.sv | 33 +++
 rtl/rr_priority_pick.sv | 32 +++
 rtl/breach_dispatcher.sv | 131 +++++++++++++
 tb/tb_breach_dispatcher.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared encodings and timing constants for the breach dispatcher.
// Optional build macro DISPATCH_PREEMPT_EN is consumed by breach_dispatcher.
package dispatch_pkg;

  localparam int NUM_SECTORS     = 3;
  localparam int TRAVEL_CYCLES   = 4;
  localparam int SERVICE_TIMEOUT = 40;
  localparam int COOL_CYCLES     = 2;
  localparam int TIMER_W         = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TRAVEL   = 3'd1,
    ST_SERVICE  = 3'd2,
    ST_COOLDOWN = 3'd3
  } state_e;

  // Timer values at which a timed state has completed its span.
  localparam logic [TIMER_W-1:0] TRAVEL_LAST   = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SERVICE_LIMIT = TIMER_W'(SERVICE_TIMEOUT);
  localparam logic [TIMER_W-1:0] COOL_LAST     = TIMER_W'(COOL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX     = '1;

  // Pointer value that makes sector 0 the first round-robin choice.
  localparam logic [1:0] PTR_RESET = 2'd2;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_SECTORS-1:0] oh);
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Three-way round-robin picker: searches upward from the sector after 'last'
// and returns a one-hot pick (zero when nothing is requested).
module rr_priority_pick
  import dispatch_pkg::*;
(
  input  logic [NUM_SECTORS-1:0] req,
  input  logic [1:0]             last,
  output logic [NUM_SECTORS-1:0] pick
);

  always_comb begin
    pick = '0;
    case (last)
      2'd0: begin
        if      (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      2'd1: begin
        if      (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if      (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/breach_dispatcher.sv
// Assigns one shared response team to the most severe requesting sector.
// Define DISPATCH_PREEMPT_EN to let a new red breach preempt a yellow-only job.
//
// state     | meaning
// IDLE      | no assignment, arbitrate pending requests
// TRAVEL    | team en route to granted sector
// SERVICE   | team working; ends on done or timeout
// COOLDOWN  | team released, grant cleared
module breach_dispatcher
  import dispatch_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SECTORS-1:0] sec_yellow,
  input  logic [NUM_SECTORS-1:0] sec_red,
  input  logic                   done,
  output logic [NUM_SECTORS-1:0] grant,
  output logic [2:0]             state,
  output logic [TIMER_W-1:0]     timer,
  output logic                   alarm,
  output logic                   timeout
);

  state_e                   state_q, state_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic [NUM_SECTORS-1:0]   grant_q, grant_d;
  logic                     timeout_q, timeout_d;
  logic [1:0]               last_q, last_d;

  logic [NUM_SECTORS-1:0]   req, red_pick, yel_pick, new_pick;
  logic                     granted_req, preempt, restart;

  assign req         = sec_red | sec_yellow;
  assign granted_req = |(grant_q & req);

  rr_priority_pick u_pick_red (
    .req  (sec_red),
    .last (last_q),
    .pick (red_pick)
  );

  rr_priority_pick u_pick_yel (
    .req  (sec_yellow),
    .last (last_q),
    .pick (yel_pick)
  );

  assign new_pick = (|sec_red) ? red_pick : yel_pick;

`ifdef DISPATCH_PREEMPT_EN
  // Any red while the granted sector is not red must be on another sector.
  assign preempt = (|sec_red) && !(|(grant_q & sec_red));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    restart   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (|req) begin
          state_d = ST_TRAVEL;
          grant_d = new_pick;
        end
      end
      ST_TRAVEL: begin
        if (preempt) begin
          grant_d = red_pick;
          restart = 1'b1;
        end else if (!granted_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (timer_q == TRAVEL_LAST) begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (preempt) begin
          state_d = ST_TRAVEL;
          grant_d = red_pick;
        end else if (done || timer_q == SERVICE_LIMIT) begin
          // done takes precedence so a timeout is only flagged without it
          state_d   = ST_COOLDOWN;
          grant_d   = '0;
          last_d    = onehot_to_idx(grant_q);
          timeout_d = !done;
        end
      end
      ST_COOLDOWN: begin
        grant_d = '0;
        if (timer_q == COOL_LAST) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    if (restart || state_d != state_q) timer_d = '0;
    else if (timer_q == TIMER_MAX)     timer_d = timer_q;
    else                               timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
      last_q    <= PTR_RESET;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
    end
  end

  assign state   = state_q;
  assign timer   = timer_q;
  assign grant   = grant_q;
  assign timeout = timeout_q;
  assign alarm   = |(sec_red & ~grant_q);

endmodule

// File: tb/tb_breach_dispatcher.sv
// Self-checking bench for breach_dispatcher: a vector table for the basic
// dispatch flow plus hand-written sequences for timeout, round-robin and preemption.
module tb_breach_dispatcher;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sec_yellow = '0;
  logic [2:0] sec_red = '0;
  logic       done = 1'b0;
  logic [2:0] grant;
  logic [2:0] state;
  logic [5:0] timer;
  logic       alarm;
  logic       timeout;

  localparam logic [2:0] I = 3'd0;
  localparam logic [2:0] T = 3'd1;
  localparam logic [2:0] S = 3'd2;
  localparam logic [2:0] C = 3'd3;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [2:0] g;
    logic [5:0] t;
    logic       to;
    logic       al;
  } exp_t;

  typedef struct {
    logic [2:0] y;
    logic [2:0] r;
    logic       d;
    logic       rst;
    logic [2:0] st;
    logic [2:0] g;
    logic [5:0] t;
    logic       to;
    logic       al;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[15];
  logic [2:0] rr_seq[4];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clock = ~clock;

  breach_dispatcher dut (
    .clock      (clock),
    .reset      (reset),
    .sec_yellow (sec_yellow),
    .sec_red    (sec_red),
    .done       (done),
    .grant      (grant),
    .state      (state),
    .timer      (timer),
    .alarm      (alarm),
    .timeout    (timeout)
  );

  // One clock: drive on the falling edge, check just after the rising edge.
  task automatic cyc(input string tag, input logic [2:0] y, input logic [2:0] r,
                     input logic d, input logic rst, input logic [2:0] est,
                     input logic [2:0] eg, input logic [5:0] et, input logic eto,
                     input logic eal);
    exp_t e;
    @(negedge clock);
    reset      = rst;
    sec_yellow = y;
    sec_red    = r;
    done       = d;
    e.tag = tag; e.st = est; e.g = eg; e.t = et; e.to = eto; e.al = eal;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (state !== e.st || grant !== e.g || timer !== e.t || timeout !== e.to || alarm !== e.al) begin
      n_fail++;
      $display("FAIL %s @%0t: got state=%0d grant=%b timer=%0d timeout=%b alarm=%b, expected state=%0d grant=%b timer=%0d timeout=%b alarm=%b",
               e.tag, $time, state, grant, timer, timeout, alarm, e.st, e.g, e.t, e.to, e.al);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           y       r       d     rst   st  g       t      to    al
    tbl[0]  = '{3'b000, 3'b101, 1'b0, 1'b1, I, 3'b000, 6'd0, 1'b0, 1'b1};
    tbl[1]  = '{3'b000, 3'b000, 1'b0, 1'b1, I, 3'b000, 6'd0, 1'b0, 1'b0};
    tbl[2]  = '{3'b010, 3'b000, 1'b0, 1'b0, T, 3'b010, 6'd0, 1'b0, 1'b0};
    tbl[3]  = '{3'b010, 3'b000, 1'b1, 1'b0, T, 3'b010, 6'd1, 1'b0, 1'b0};
    tbl[4]  = '{3'b010, 3'b000, 1'b0, 1'b0, T, 3'b010, 6'd2, 1'b0, 1'b0};
    tbl[5]  = '{3'b010, 3'b000, 1'b0, 1'b0, T, 3'b010, 6'd3, 1'b0, 1'b0};
    tbl[6]  = '{3'b010, 3'b000, 1'b0, 1'b0, S, 3'b010, 6'd0, 1'b0, 1'b0};
    tbl[7]  = '{3'b010, 3'b000, 1'b0, 1'b0, S, 3'b010, 6'd1, 1'b0, 1'b0};
    tbl[8]  = '{3'b010, 3'b000, 1'b0, 1'b0, S, 3'b010, 6'd2, 1'b0, 1'b0};
    tbl[9]  = '{3'b010, 3'b000, 1'b0, 1'b0, S, 3'b010, 6'd3, 1'b0, 1'b0};
    tbl[10] = '{3'b000, 3'b000, 1'b1, 1'b0, C, 3'b000, 6'd0, 1'b0, 1'b0};
    tbl[11] = '{3'b000, 3'b000, 1'b0, 1'b0, C, 3'b000, 6'd1, 1'b0, 1'b0};
    tbl[12] = '{3'b000, 3'b000, 1'b0, 1'b0, I, 3'b000, 6'd0, 1'b0, 1'b0};
    tbl[13] = '{3'b000, 3'b000, 1'b0, 1'b0, I, 3'b000, 6'd1, 1'b0, 1'b0};
    tbl[14] = '{3'b001, 3'b100, 1'b0, 1'b0, T, 3'b100, 6'd0, 1'b0, 1'b0};
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};

    // Basic yellow dispatch, done ignored in TRAVEL, red outranks yellow.
    foreach (tbl[k])
      cyc($sformatf("table[%0d]", k), tbl[k].y, tbl[k].r, tbl[k].d, tbl[k].rst,
          tbl[k].st, tbl[k].g, tbl[k].t, tbl[k].to, tbl[k].al);

    // Idle timer saturates at 63.
    cyc("sat_reset", 3'b000, 3'b000, 1'b0, 1'b1, I, 3'b000, 6'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 66; i++)
      cyc("idle_sat", 3'b000, 3'b000, 1'b0, 1'b0, I, 3'b000, (i > 63) ? 6'd63 : 6'(i), 1'b0, 1'b0);

    // Red on sector 0 with no done: timeout raised after SERVICE timer=40.
    cyc("to_reset", 3'b000, 3'b000, 1'b0, 1'b1, I, 3'b000, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("to_travel", 3'b000, 3'b001, 1'b0, 1'b0, T, 3'b001, 6'(i), 1'b0, 1'b0);
    for (int i = 0; i <= 40; i++)
      cyc("to_service", 3'b000, 3'b001, 1'b0, 1'b0, S, 3'b001, 6'(i), 1'b0, 1'b0);
    cyc("to_pulse", 3'b000, 3'b001, 1'b0, 1'b0, C, 3'b000, 6'd0, 1'b1, 1'b1);
    cyc("to_cool1", 3'b000, 3'b001, 1'b0, 1'b0, C, 3'b000, 6'd1, 1'b0, 1'b1);
    cyc("to_idle", 3'b000, 3'b001, 1'b0, 1'b0, I, 3'b000, 6'd0, 1'b0, 1'b1);
    cyc("to_regrant", 3'b000, 3'b001, 1'b0, 1'b0, T, 3'b001, 6'd0, 1'b0, 1'b0);

    // done coinciding with the timeout point: done wins, no pulse.
    for (int i = 1; i < 4; i++)
      cyc("dt_travel", 3'b000, 3'b001, 1'b0, 1'b0, T, 3'b001, 6'(i), 1'b0, 1'b0);
    for (int i = 0; i <= 40; i++)
      cyc("dt_service", 3'b000, 3'b001, 1'b0, 1'b0, S, 3'b001, 6'(i), 1'b0, 1'b0);
    cyc("dt_done_wins", 3'b000, 3'b001, 1'b1, 1'b0, C, 3'b000, 6'd0, 1'b0, 1'b1);
    cyc("dt_cool1", 3'b000, 3'b000, 1'b0, 1'b0, C, 3'b000, 6'd1, 1'b0, 1'b0);
    cyc("dt_idle", 3'b000, 3'b000, 1'b0, 1'b0, I, 3'b000, 6'd0, 1'b0, 1'b0);

    // Round-robin over three yellows.
    cyc("rr_reset", 3'b000, 3'b000, 1'b0, 1'b1, I, 3'b000, 6'd0, 1'b0, 1'b0);
    foreach (rr_seq[k]) begin
      cyc($sformatf("rr_grant%0d", k), 3'b111, 3'b000, 1'b0, 1'b0, T, rr_seq[k], 6'd0, 1'b0, 1'b0);
      for (int i = 1; i < 4; i++)
        cyc("rr_travel", 3'b111, 3'b000, 1'b0, 1'b0, T, rr_seq[k], 6'(i), 1'b0, 1'b0);
      cyc("rr_service", 3'b111, 3'b000, 1'b0, 1'b0, S, rr_seq[k], 6'd0, 1'b0, 1'b0);
      cyc("rr_done", 3'b111, 3'b000, 1'b1, 1'b0, C, 3'b000, 6'd0, 1'b0, 1'b0);
      cyc("rr_cool1", 3'b111, 3'b000, 1'b0, 1'b0, C, 3'b000, 6'd1, 1'b0, 1'b0);
      cyc("rr_idle", 3'b111, 3'b000, 1'b0, 1'b0, I, 3'b000, 6'd0, 1'b0, 1'b0);
    end

    // Request dropped at TRAVEL timer=2 (pointer left at sector 0 from above).
    cyc("drop_t0", 3'b100, 3'b000, 1'b0, 1'b0, T, 3'b100, 6'd0, 1'b0, 1'b0);
    cyc("drop_t1", 3'b100, 3'b000, 1'b0, 1'b0, T, 3'b100, 6'd1, 1'b0, 1'b0);
    cyc("drop_t2", 3'b100, 3'b000, 1'b0, 1'b0, T, 3'b100, 6'd2, 1'b0, 1'b0);
    cyc("drop_idle", 3'b000, 3'b000, 1'b0, 1'b0, I, 3'b000, 6'd0, 1'b0, 1'b0);
    cyc("drop_idle1", 3'b000, 3'b000, 1'b0, 1'b0, I, 3'b000, 6'd1, 1'b0, 1'b0);

    // Reset mid-SERVICE, then pointer must be back to sector 0 first.
    for (int i = 0; i < 4; i++)
      cyc("mr_travel", 3'b100, 3'b000, 1'b0, 1'b0, T, 3'b100, 6'(i), 1'b0, 1'b0);
    cyc("mr_service0", 3'b100, 3'b000, 1'b0, 1'b0, S, 3'b100, 6'd0, 1'b0, 1'b0);
    cyc("mr_service1", 3'b100, 3'b000, 1'b0, 1'b0, S, 3'b100, 6'd1, 1'b0, 1'b0);
    cyc("mr_reset", 3'b100, 3'b000, 1'b0, 1'b1, I, 3'b000, 6'd0, 1'b0, 1'b0);
    cyc("mr_rr_ptr", 3'b011, 3'b000, 1'b0, 1'b0, T, 3'b001, 6'd0, 1'b0, 1'b0);

    // Red on sector 2 while yellow sector 0 is in SERVICE.
    cyc("pe_reset", 3'b000, 3'b000, 1'b0, 1'b1, I, 3'b000, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("pe_travel", 3'b001, 3'b000, 1'b0, 1'b0, T, 3'b001, 6'(i), 1'b0, 1'b0);
    cyc("pe_service", 3'b001, 3'b000, 1'b0, 1'b0, S, 3'b001, 6'd0, 1'b0, 1'b0);
`ifdef DISPATCH_PREEMPT_EN
    cyc("pe_regrant", 3'b001, 3'b100, 1'b0, 1'b0, T, 3'b100, 6'd0, 1'b0, 1'b0);
    cyc("pe_travel1", 3'b001, 3'b100, 1'b0, 1'b0, T, 3'b100, 6'd1, 1'b0, 1'b0);
`else
    cyc("np_alarm1", 3'b001, 3'b100, 1'b0, 1'b0, S, 3'b001, 6'd1, 1'b0, 1'b1);
    cyc("np_alarm2", 3'b001, 3'b100, 1'b0, 1'b0, S, 3'b001, 6'd2, 1'b0, 1'b1);
    cyc("np_done", 3'b001, 3'b100, 1'b1, 1'b0, C, 3'b000, 6'd0, 1'b0, 1'b1);
    cyc("np_cool1", 3'b001, 3'b100, 1'b0, 1'b0, C, 3'b000, 6'd1, 1'b0, 1'b1);
    cyc("np_idle", 3'b001, 3'b100, 1'b0, 1'b0, I, 3'b000, 6'd0, 1'b0, 1'b1);
    cyc("np_red_grant", 3'b001, 3'b100, 1'b0, 1'b0, T, 3'b100, 6'd0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
